spread_stats: RTL and testbench
===============================

Name: spread_stats

Overview:
Parametrised successor to the per-match spread register in the order-book datapath. On each qualified match it computes the absolute bid/ask spread and presents it one cycle later. It also maintains min/max since the last clear, plus a sliding-window average over the last DEPTH matches. Consumers are the HEX/VGA display path and the market-stats logger.

Parameters:
PW, 8, price and spread width in bits
DEPTH, 8, averaging window length in samples; power of 2, at least 2
IDLE_SPREAD, 88, code driven on spread_now in non-sample cycles (non-hold build only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable_count  in  1  statistics gate from control FSM
match_signal  in  1  one-cycle pulse on a trade match
buy_price  in  PW  best bid; 0 = empty bid side
sell_price  in  PW  best ask; all-ones = empty ask side
clear_stats  in  1  clears min/max/window/count; does not affect spread_now
spread_now  out  PW  last spread or IDLE_SPREAD
spread_valid  out  1  1-cycle pulse: spread_now updated from a sample
crossed  out  1  registered with sample: buy_price >= sell_price
invalid_pulse  out  1  1-cycle pulse: a match was gated but the quote was invalid
spread_min  out  PW  minimum since reset/clear; all-ones when empty
spread_max  out  PW  maximum since reset/clear; 0 when empty
spread_avg  out  PW  window sum >> log2(DEPTH)
avg_valid  out  1  high once the window holds DEPTH samples
sample_count  out  $clog2(DEPTH)+1  samples in window, saturates at DEPTH

Behaviour:
- Reset is synchronous and active-high; clk and reset are the only clock and reset.
- Reset values: spread_now=0, spread_valid=0, crossed=0, invalid_pulse=0, spread_min=all-ones, spread_max=0, spread_avg=0, avg_valid=0, sample_count=0, window buffer and sum=0.
- Gated match: match_signal && enable_count.
- Quote is invalid if sell_price == all-ones or buy_price == 0.
- Sample: a gated match with a valid quote. A gated match with an invalid quote raises invalid_pulse only; no stats change.
- Spread = |buy_price - sell_price|, PW bits, no overflow possible.
- Latency: every output reflects the sample on the clk edge that follows it (1 cycle).
- Window:
  - Circular buffer of DEPTH entries.
  - Running sum is PW+log2(DEPTH) bits; on a sample, sum <= sum + new - evicted.
  - Evicted is 0 until the window is full.
  - Write pointer wraps DEPTH-1 -> 0.
- spread_avg updates every sample; it is meaningful only when avg_valid=1.
- Min/max are cumulative since reset/clear, not windowed.
- clear_stats and a sample in the same cycle: clear takes priority. The sample then becomes the first post-clear entry: min=max=spread, count=1, sum=spread.
- clear_stats mid-window: pointer, sum, buffer and count return to 0. spread_now and crossed keep their values.
- reset takes priority over everything.
- No FSM beyond the fill phase (count<DEPTH) and full phase (avg_valid=1).

Optional Feature:
Macro SPREAD_HOLD_LAST_EN.
- Defined: spread_now and crossed hold the last sample value in non-sample cycles.
- Undefined: spread_now = IDLE_SPREAD and crossed = 0 on every cycle without a sample, including invalid matches.
- Stats logic is identical in both builds.

Decomposition:
- spread_pkg holds: PRICE_W default, EMPTY_BID (0), EMPTY_ASK (all-ones) and IDLE_SPREAD constants, plus the function abs_diff.
- One sub-module, spread_window: circular buffer, pointer, running sum, saturating count and clear.
- Top level holds spread compute, qualification, min/max and output registers.

Test Plan:
All scenarios use PW=8, DEPTH=4, macro undefined unless noted.
1. Reset asserted 2 cycles -> spread_now=0, min=FF, max=0, count=0, avg_valid=0.
2. buy=100, sell=97, match=1, enable=1 -> next cycle spread_now=3, spread_valid=1, crossed=1, min=max=3, count=1. Following idle cycle -> spread_now=88.
3. buy=50, sell=FF, match=1, enable=1 -> invalid_pulse=1, spread_now=88, count/min/max unchanged.
4. Samples 4, 8, 12, 16 -> avg=10, avg_valid=1, count=4. Then sample 20 -> avg=14, count stays 4, min=4, max=20.
5. Window full, then clear_stats together with sample 7 -> min=max=7, count=1, avg_valid=0, avg=1.
6. Macro defined: enable=0, match=1, quote 90/80 after prior sample 5 -> no sample, spread_now holds 5, spread_valid=0.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared constants and helpers for the spread statistics block.
package spread_pkg;

    localparam int PRICE_W = 8;
    localparam int MAX_W   = 32;

    localparam logic [PRICE_W-1:0] EMPTY_BID   = '0;
    localparam logic [PRICE_W-1:0] EMPTY_ASK   = '1;
    localparam logic [PRICE_W-1:0] IDLE_SPREAD = 8'd88;

    function automatic logic [MAX_W-1:0] abs_diff(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/spread_stats_if.sv
// Quote/match inputs and statistics outputs of spread_stats.
interface spread_stats_if #(
    parameter int PW    = spread_pkg::PRICE_W,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enable_count;
    logic          match_signal;
    logic [PW-1:0] buy_price;
    logic [PW-1:0] sell_price;
    logic          clear_stats;
    logic [PW-1:0] spread_now;
    logic          spread_valid;
    logic          crossed;
    logic          invalid_pulse;
    logic [PW-1:0] spread_min;
    logic [PW-1:0] spread_max;
    logic [PW-1:0] spread_avg;
    logic          avg_valid;
    logic [CW-1:0] sample_count;

    modport master (
        output enable_count, match_signal, buy_price, sell_price, clear_stats,
        input  spread_now, spread_valid, crossed, invalid_pulse,
        input  spread_min, spread_max, spread_avg, avg_valid, sample_count
    );

    modport slave (
        input  enable_count, match_signal, buy_price, sell_price, clear_stats,
        output spread_now, spread_valid, crossed, invalid_pulse,
        output spread_min, spread_max, spread_avg, avg_valid, sample_count
    );

endinterface

// File: rtl/spread_window.sv
// Sliding window of the last DEPTH spreads: circular buffer, running sum
// and saturating fill count. Clear wins over a same-cycle sample.
module spread_window
    import spread_pkg::*;
#(
    parameter int W     = PRICE_W,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         sample,
    input  logic [W-1:0]                 data,
    output logic [W+$clog2(DEPTH)-1:0]   sum,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int LG = $clog2(DEPTH);
    localparam int SW = W + LG;

    logic [W-1:0]  win_q [DEPTH];
    logic [LG-1:0] ptr_q;
    logic [LG-1:0] ptr_nxt;
    logic [SW-1:0] sum_q;
    logic [LG:0]   cnt_q;
    logic          full;
    logic [W-1:0]  evicted;

    assign full    = (cnt_q == (LG+1)'(DEPTH));
    assign evicted = full ? win_q[ptr_q] : '0;
    assign ptr_nxt = (ptr_q == LG'(DEPTH-1)) ? '0 : ptr_q + LG'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
            ptr_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            // a sample arriving with the clear becomes entry 0 of the new window
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
            if (sample) win_q[0] <= data;
            ptr_q <= sample ? LG'(1) : '0;
            sum_q <= sample ? SW'(data) : '0;
            cnt_q <= {{LG{1'b0}}, sample};
        end else if (sample) begin
            win_q[ptr_q] <= data;
            ptr_q <= ptr_nxt;
            sum_q <= sum_q + SW'(data) - SW'(evicted);
            if (!full) cnt_q <= cnt_q + (LG+1)'(1);
        end
    end

    assign sum   = sum_q;
    assign count = cnt_q;

endmodule

// File: rtl/spread_stats.sv
// Per-match bid/ask spread with min/max and windowed average.
// SPREAD_HOLD_LAST_EN: hold spread_now/crossed between samples.
module spread_stats #(
    parameter int            PW          = spread_pkg::PRICE_W,
    parameter int            DEPTH       = 8,
    parameter logic [PW-1:0] IDLE_SPREAD = PW'(spread_pkg::IDLE_SPREAD)
) (
    input  logic           clk,
    input  logic           reset,
    spread_stats_if.slave  bus
);

    localparam int LG = $clog2(DEPTH);
    localparam int AW = spread_pkg::MAX_W;

    logic          gated;
    logic          quote_ok;
    logic          sample;
    logic          bad_quote;
    logic          is_cross;
    logic [PW-1:0] diff;

    logic [PW-1:0] now_q;
    logic          valid_q;
    logic          cross_q;
    logic          inv_q;
    logic [PW-1:0] min_q;
    logic [PW-1:0] max_q;

    logic [PW+LG-1:0] win_sum;
    logic [LG:0]      win_cnt;

    assign gated     = bus.match_signal & bus.enable_count;
    assign quote_ok  = (bus.sell_price != '1) && (bus.buy_price != '0);
    assign sample    = gated & quote_ok;
    assign bad_quote = gated & ~quote_ok;
    assign is_cross  = (bus.buy_price >= bus.sell_price);
    assign diff      = PW'(spread_pkg::abs_diff(AW'(bus.buy_price),
                                                 AW'(bus.sell_price)));

    always_ff @(posedge clk) begin
        if (reset) begin
            now_q   <= '0;
            valid_q <= 1'b0;
            cross_q <= 1'b0;
            inv_q   <= 1'b0;
            min_q   <= '1;
            max_q   <= '0;
        end else begin
            valid_q <= sample;
            inv_q   <= bad_quote;
`ifdef SPREAD_HOLD_LAST_EN
            if (sample) begin
                now_q   <= diff;
                cross_q <= is_cross;
            end
`else
            now_q   <= sample ? diff : IDLE_SPREAD;
            cross_q <= sample & is_cross;
`endif
            if (bus.clear_stats) begin
                min_q <= sample ? diff : '1;
                max_q <= sample ? diff : '0;
            end else if (sample) begin
                if (diff < min_q) min_q <= diff;
                if (diff > max_q) max_q <= diff;
            end
        end
    end

    spread_window #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_window (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus.clear_stats),
        .sample (sample),
        .data   (diff),
        .sum    (win_sum),
        .count  (win_cnt)
    );

    assign bus.spread_now    = now_q;
    assign bus.spread_valid  = valid_q;
    assign bus.crossed       = cross_q;
    assign bus.invalid_pulse = inv_q;
    assign bus.spread_min    = min_q;
    assign bus.spread_max    = max_q;
    assign bus.spread_avg    = win_sum[PW+LG-1:LG];
    assign bus.avg_valid     = (win_cnt == (LG+1)'(DEPTH));
    assign bus.sample_count  = win_cnt;

endmodule

// File: tb/tb_spread_stats.sv
// Directed plus random bench for spread_stats against a queue-based model.
module tb_spread_stats;

    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int IDLE  = 88;
    localparam int ONES  = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spread_stats_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

    spread_stats #(
        .PW          (PW),
        .DEPTH       (DEPTH),
        .IDLE_SPREAD (8'd88)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: window as a queue of spreads, oldest first
    int win[$];
    int m_min, m_max, m_now, m_cross, m_valid, m_inv;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_min   = ONES;
        m_max   = 0;
        m_now   = 0;
        m_cross = 0;
        m_valid = 0;
        m_inv   = 0;
    endtask

    task automatic model_step(bit e, bit m, int b, int s, bit c);
        bit gated, ok, smp;
        int sp;
        gated = m && e;
        ok    = (s != ONES) && (b != 0);
        smp   = gated && ok;
        sp    = (b > s) ? b - s : s - b;
        if (c) begin
            win.delete();
            m_min = ONES;
            m_max = 0;
        end
        if (smp) begin
            win.push_back(sp);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (sp < m_min) m_min = sp;
            if (sp > m_max) m_max = sp;
        end
        m_valid = smp;
        m_inv   = gated && !ok;
`ifdef SPREAD_HOLD_LAST_EN
        if (smp) begin
            m_now   = sp;
            m_cross = (b >= s);
        end
`else
        m_now   = smp ? sp : IDLE;
        m_cross = smp && (b >= s);
`endif
    endtask

    task automatic check_all(string tag);
        int sum;
        sum = 0;
        foreach (win[i]) sum += win[i];
        chk({tag, ".now"},   bus.spread_now,    m_now);
        chk({tag, ".valid"}, bus.spread_valid,  m_valid);
        chk({tag, ".cross"}, bus.crossed,       m_cross);
        chk({tag, ".inv"},   bus.invalid_pulse, m_inv);
        chk({tag, ".min"},   bus.spread_min,    m_min);
        chk({tag, ".max"},   bus.spread_max,    m_max);
        chk({tag, ".avg"},   bus.spread_avg,    (sum / DEPTH) & ONES);
        chk({tag, ".avgv"},  bus.avg_valid,     win.size() == DEPTH);
        chk({tag, ".cnt"},   bus.sample_count,  win.size());
    endtask

    task automatic apply(string tag, bit r, bit e, bit m, int b, int s, bit c);
        reset            = r;
        bus.enable_count = e;
        bus.match_signal = m;
        bus.buy_price    = b[PW-1:0];
        bus.sell_price   = s[PW-1:0];
        bus.clear_stats  = c;
        if (r) model_reset();
        else model_step(e, m, b, s, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic samp(string tag, int sp);
        apply(tag, 0, 1, 1, sp + 10, 10, 0);
    endtask

    initial begin
        int b, s;
        bit e, m, c, r;
        reset            = 1'b1;
        bus.enable_count = 1'b0;
        bus.match_signal = 1'b0;
        bus.buy_price    = '0;
        bus.sell_price   = '0;
        bus.clear_stats  = 1'b0;

        apply("rst0", 1, 0, 0, 0, 0, 0);
        apply("rst1", 1, 0, 0, 0, 0, 0);
        chk("rst.min", bus.spread_min, 255);
        chk("rst.now", bus.spread_now, 0);

        apply("t2", 0, 1, 1, 100, 97, 0);
        chk("t2.now", bus.spread_now, 3);
        chk("t2.cross", bus.crossed, 1);
        apply("t2i", 0, 0, 0, 100, 97, 0);
`ifndef SPREAD_HOLD_LAST_EN
        chk("t2i.now", bus.spread_now, 88);
`endif

        apply("t3", 0, 1, 1, 50, 255, 0);
        chk("t3.inv", bus.invalid_pulse, 1);
        apply("t3b", 0, 1, 1, 0, 40, 0);

        apply("clr", 0, 0, 0, 0, 0, 1);
        samp("t4a", 4);
        samp("t4b", 8);
        samp("t4c", 12);
        samp("t4d", 16);
        chk("t4.avg", bus.spread_avg, 10);
        chk("t4.avgv", bus.avg_valid, 1);
        samp("t4e", 20);
        chk("t4e.avg", bus.spread_avg, 14);
        chk("t4e.cnt", bus.sample_count, 4);
        chk("t4e.min", bus.spread_min, 4);
        chk("t4e.max", bus.spread_max, 20);

        apply("t5", 0, 1, 1, 17, 10, 1);
        chk("t5.avg", bus.spread_avg, 1);
        chk("t5.cnt", bus.sample_count, 1);

        samp("t6a", 5);
        apply("t6b", 0, 0, 1, 90, 80, 0);
        chk("t6b.valid", bus.spread_valid, 0);

        // ptr wrap across several full windows
        for (int i = 0; i < 10; i++) samp("wrap", 3 * i + 1);

        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 4) != 0);
            m = $urandom_range(0, 1);
            c = ($urandom_range(0, 24) == 0);
            b = $urandom_range(0, ONES);
            s = $urandom_range(0, ONES);
            if ($urandom_range(0, 11) == 0) b = 0;
            if ($urandom_range(0, 11) == 0) s = ONES;
            apply("rnd", r, e, m, b, s, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
